pipe_barrelshifter: RTL and testbench
=====================================

PIPE_BARRELSHIFTER -- requirements
Module: pipe_barrelshifter

Interface
REQ-001 SHALL take parameter D_SIZE, default 32, data width; legal values are powers of 2 from 4 to 64, and any other value SHALL fail elaboration.
REQ-002 SHALL define LOG2 = $clog2(D_SIZE), used as the shift-amount width and the pipeline depth.
REQ-003 Port clk_in, input, 1 bit: single clock, rising edge.
REQ-004 Port rst_n_in, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port valid_in, input, 1 bit: input operands valid.
REQ-006 Port ready_in, output, 1 bit: block can accept input.
REQ-007 Port x_in, input, D_SIZE bits: operand.
REQ-008 Port s_in, input, LOG2 bits: shift amount, 0..D_SIZE-1.
REQ-009 Port op_in, input, 3 bits: operation code.
REQ-010 Port clr_in, input, 1 bit: synchronous clear of vf_sticky_out.
REQ-011 Port valid_out, output, 1 bit: result valid.
REQ-012 Port ready_out, input, 1 bit: downstream accepts the result.
REQ-013 Port y_out, output, D_SIZE bits: result.
REQ-014 Port zf_out, output, 1 bit: zero flag for y_out.
REQ-015 Port vf_out, output, 1 bit: overflow flag for y_out.
REQ-016 Port vf_sticky_out, output, 1 bit: OR of vf_out over all delivered results since reset or clear.

Function
REQ-017 SHALL decode op_in as follows: 000 SRL (zero fill); 001 SRA (sign fill); 01x ROR; 100 SLL; 101 SLA (zero fill); 11x ROL.
REQ-018 SHALL implement LOG2 mux levels, level i shifting by 2^i when s_in[i]=1, highest level first, with each level followed by a pipeline register.
REQ-019 SHALL carry op, sign bit and valid alongside the data through every pipeline stage.
REQ-020 SHALL give a latency of exactly LOG2 rising edges: for a transaction accepted on edge 1, valid_out and its result SHALL appear after edge LOG2.
REQ-021 SHALL accept a transaction on a rising edge only when valid_in=1 and ready_in=1.
REQ-022 SHALL drive ready_in = ~(valid_out & ~ready_out), so the whole pipeline stalls on output backpressure.
REQ-023 SHALL hold every stage register, y_out, zf_out and vf_out stable while stalled; bubbles are not compressed.
REQ-024 SHALL register zf_out with y_out, with zf_out=1 iff y_out is all zeros.
REQ-025 SHALL compute vf at acceptance and pipe it to the output.
REQ-026 SHALL set vf=1 only for SLA with s>0, and only when any of x[D_SIZE-2 : D_SIZE-1-s] differs from x[D_SIZE-1]; vf=0 for every other op and for s=0.
REQ-027 SHALL treat s_in=0 as a pass-through for all ops: y equals x and vf=0.
REQ-028 SHALL set vf_sticky_out on any edge where valid_out & ready_out & vf_out = 1.
REQ-029 SHALL clear vf_sticky_out when clr_in=1; if clr_in coincides with a set event, the set SHALL win.
REQ-030 SHALL update vf_sticky_out regardless of valid_in.
REQ-031 SHALL keep y_out, zf_out and vf_out at their previous values while valid_out=0, with no X propagation.

Reset
REQ-032 While rst_n_in=0, all valid bits, y_out, vf_out and vf_sticky_out SHALL be 0, zf_out SHALL be 1, and ready_in SHALL be 1, asynchronously.
REQ-033 Reset mid-operation SHALL discard all in-flight transactions; no result from before reset SHALL ever appear on valid_out.
REQ-034 After rst_n_in deasserts, the first edge SHALL be able to accept a transaction.

Verification (D_SIZE=8, LOG2=3)
REQ-035 SRA: x=8'b1001_0110, s=3 -> after 3 edges y=8'b1111_0010, zf=0, vf=0.
REQ-036 ROL then ROR back-to-back: x=8'h81, s=1 -> 8'h03; then x=8'h81, s=1 ROR -> 8'hC0 on the next cycle, both with valid_out in consecutive cycles.
REQ-037 SLA: x=8'h40, s=1 -> y=8'h80, vf=1, vf_sticky_out=1 after delivery; then clr_in pulse -> vf_sticky_out=0; SLL with the same operands -> y=8'h80, vf=0.
REQ-038 SRL: x=8'h01, s=1 -> y=8'h00, zf=1.
REQ-039 Backpressure: issue 5 transactions while ready_out=0 -> ready_in drops once valid_out=1, y_out stays held, and after ready_out=1 all 5 results appear in order with none lost or duplicated.
REQ-040 Reset mid-operation: assert rst_n_in with 2 transactions in flight -> valid_out=0 immediately and no stale result appears after reset release.

Source files
------------

// File: rtl/pipe_barrelshifter.sv
// Pipelined barrel shifter/rotator (SRL/SRA/ROR/SLL/SLA/ROL): one shift level per register stage, LOG2-cycle latency.
// A stalled output (valid_out & ~ready_out) freezes every stage and drops ready_in; bubbles are kept, never squeezed.
module pipe_barrelshifter #(
  parameter int D_SIZE = 32,
  localparam int LOG2 = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [D_SIZE-1:0] x_in,
  input  logic [LOG2-1:0]   s_in,
  input  logic [2:0]        op_in,
  input  logic              clr_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out,
  output logic              vf_sticky_out
);

  generate
    if (!(D_SIZE == 4 || D_SIZE == 8 || D_SIZE == 16 || D_SIZE == 32 || D_SIZE == 64)) begin : g_bad_size
      $error("pipe_barrelshifter: D_SIZE must be a power of 2 between 4 and 64");
    end
  endgenerate

  typedef struct packed {
    logic              vld;
    logic [2:0]        op;
    logic              sign;
    logic              vf;
    logic [LOG2-1:0]   s;
    logic [D_SIZE-1:0] dat;
  } stage_t;

  stage_t st_q   [LOG2];
  stage_t st_src [LOG2];
  stage_t st_d   [LOG2];
  logic   adv;
  logic   sla_vf;
  logic   zf_q;
  logic   sticky_q;

  // op[2] selects left, op[1] selects rotate, op[0] selects sign fill on right shifts only.
  function automatic logic [D_SIZE-1:0] shift_level(
    input logic [D_SIZE-1:0] d,
    input int                k,
    input logic [2:0]        op,
    input logic              sign
  );
    logic [D_SIZE-1:0] r;
    r = '0;
    for (int j = 0; j < D_SIZE; j++) begin
      if (op[2]) begin
        if (j >= k)
          r[j] = d[j-k];
        else if (op[1])
          r[j] = d[j-k+D_SIZE];
        else
          r[j] = 1'b0;
      end else begin
        if (j + k < D_SIZE)
          r[j] = d[j+k];
        else if (op[1])
          r[j] = d[j+k-D_SIZE];
        else
          r[j] = op[0] ? sign : 1'b0;
      end
    end
    return r;
  endfunction

  // SLA overflows when any bit shifted through the sign position disagrees with the original sign.
  always_comb begin
    sla_vf = 1'b0;
    if (op_in == 3'b101) begin
      for (int j = 1; j < D_SIZE; j++) begin
        if (j <= int'(s_in) && x_in[D_SIZE-1-j] != x_in[D_SIZE-1])
          sla_vf = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LOG2; i++) begin
      if (i == 0) begin
        st_src[i].vld  = valid_in;
        st_src[i].op   = op_in;
        st_src[i].sign = x_in[D_SIZE-1];
        st_src[i].vf   = sla_vf;
        st_src[i].s    = s_in;
        st_src[i].dat  = x_in;
      end else begin
        st_src[i] = st_q[i-1];
      end
      st_d[i] = st_src[i];
      // Stage i applies the level for shift bit LOG2-1-i, so the largest shift happens first.
      if (st_src[i].s[LOG2-1-i])
        st_d[i].dat = shift_level(st_src[i].dat, 1 << (LOG2-1-i), st_src[i].op, st_src[i].sign);
    end
  end

  assign valid_out = st_q[LOG2-1].vld;
  assign ready_in  = ~(valid_out & ~ready_out);
  assign adv       = ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < LOG2; i++)
        st_q[i] <= '0;
      zf_q <= 1'b1;
    end else if (adv) begin
      for (int i = 0; i < LOG2; i++) begin
        if (st_d[i].vld)
          st_q[i] <= st_d[i];
        else
          st_q[i].vld <= 1'b0;
      end
      if (st_d[LOG2-1].vld)
        zf_q <= (st_d[LOG2-1].dat == '0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      sticky_q <= 1'b0;
    else if (valid_out && ready_out && vf_out)
      sticky_q <= 1'b1;
    else if (clr_in)
      sticky_q <= 1'b0;
  end

  assign y_out         = st_q[LOG2-1].dat;
  assign vf_out        = st_q[LOG2-1].vf;
  assign zf_out        = zf_q;
  assign vf_sticky_out = sticky_q;

endmodule

// File: tb/tb_pipe_barrelshifter.sv
// Directed bench for pipe_barrelshifter at D_SIZE=8 with an arithmetic reference model and per-cycle output checker.
module tb_pipe_barrelshifter;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] x_in;
  logic [2:0] s_in;
  logic [2:0] op_in;
  logic       clr_in;
  logic       valid_out;
  logic       ready_out;
  logic [7:0] y_out;
  logic       zf_out;
  logic       vf_out;
  logic       vf_sticky_out;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  logic [8:0] exp_q[$];
  logic [7:0] last_y;
  logic       last_vf;

  pipe_barrelshifter #(.D_SIZE(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .x_in(x_in), .s_in(s_in), .op_in(op_in), .clr_in(clr_in),
    .valid_out(valid_out), .ready_out(ready_out), .y_out(y_out),
    .zf_out(zf_out), .vf_out(vf_out), .vf_sticky_out(vf_sticky_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference result {vf, y} from plain shift/rotate arithmetic.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
    logic [7:0]        y;
    logic [15:0]       w;
    logic signed [7:0] back;
    logic              vf;
    vf = 1'b0;
    w  = {x, x};
    case (op)
      3'b000:         y = x >> s;
      3'b001:         y = $signed(x) >>> s;
      3'b010, 3'b011: begin w = w >> s; y = w[7:0]; end
      3'b100:         y = x << s;
      3'b101: begin
        y    = x << s;
        back = $signed(y) >>> s;
        vf   = (back != $signed(x));
      end
      default:        begin w = w << s; y = w[15:8]; end
    endcase
    return {vf, y};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_y  = 8'h00;
      last_vf = 1'b0;
    end else begin
      chk("ready_in_rule", ready_in, !(valid_out && !ready_out));
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", valid_out, 1'b0);
        end else begin
          chk("y_out", y_out, exp_q[0][7:0]);
          chk("zf_out", zf_out, exp_q[0][7:0] == 8'h00);
          chk("vf_out", vf_out, exp_q[0][8]);
          last_y  = exp_q[0][7:0];
          last_vf = exp_q[0][8];
          if (ready_out) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end else begin
        chk("idle_y_hold", y_out, last_y);
        chk("idle_zf_hold", zf_out, last_y == 8'h00);
        chk("idle_vf_hold", vf_out, last_vf);
      end
      if (valid_in && ready_in)
        exp_q.push_back(model(x_in, s_in, op_in));
    end
  end

  // Call just after a rising edge; returns just after the edge that accepted the transaction.
  task automatic send(input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
    int n;
    n = 0;
    valid_in = 1'b1;
    x_in = x;
    s_in = s;
    op_in = op;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", ready_in, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, valid_out, 1'b1);
  endtask

  task automatic latency(input string name);
    int edges;
    edges = 1;
    @(negedge clk);
    while (!valid_out && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk(name, edges, 3);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] xs [4];
    int base;
    xs[0] = 8'h96; xs[1] = 8'h81; xs[2] = 8'h7F; xs[3] = 8'h01;
    clk = 1'b0; rst_n = 1'b0; valid_in = 1'b0; x_in = '0; s_in = '0; op_in = '0;
    clr_in = 1'b0; ready_out = 1'b0;

    #12;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_y_out", y_out, 8'h00);
    chk("rst_zf_out", zf_out, 1'b1);
    chk("rst_vf_out", vf_out, 1'b0);
    chk("rst_sticky", vf_sticky_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b1);

    chk("model_sra", model(8'h96, 3'd3, 3'b001), {1'b0, 8'hF2});
    chk("model_rol", model(8'h81, 3'd1, 3'b110), {1'b0, 8'h03});
    chk("model_ror", model(8'h81, 3'd1, 3'b010), {1'b0, 8'hC0});
    chk("model_sla", model(8'h40, 3'd1, 3'b101), {1'b1, 8'h80});
    chk("model_sll", model(8'h40, 3'd1, 3'b100), {1'b0, 8'h80});
    chk("model_sla_s0", model(8'h40, 3'd0, 3'b101), {1'b0, 8'h40});

    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_out = 1'b1;

    send(8'h96, 3'd3, 3'b001);
    latency("sra_latency");
    chk("sra_y", y_out, 8'hF2);
    chk("sra_zf", zf_out, 1'b0);
    chk("sra_vf", vf_out, 1'b0);
    @(posedge clk); #1;

    send(8'h81, 3'd1, 3'b110);
    send(8'h81, 3'd1, 3'b010);
    wait_out("rol_valid");
    chk("rol_y", y_out, 8'h03);
    @(negedge clk);
    chk("ror_consecutive", valid_out, 1'b1);
    chk("ror_y", y_out, 8'hC0);
    @(posedge clk); #1;

    send(8'h40, 3'd1, 3'b101);
    wait_out("sla_valid");
    chk("sla_y", y_out, 8'h80);
    chk("sla_vf", vf_out, 1'b1);
    @(posedge clk); #1;
    chk("sticky_set", vf_sticky_out, 1'b1);
    clr_in = 1'b1;
    @(posedge clk); #1;
    clr_in = 1'b0;
    chk("sticky_clr", vf_sticky_out, 1'b0);
    send(8'h40, 3'd1, 3'b100);
    wait_out("sll_valid");
    chk("sll_y", y_out, 8'h80);
    chk("sll_vf", vf_out, 1'b0);
    @(posedge clk); #1;
    chk("sticky_stays_clr", vf_sticky_out, 1'b0);

    send(8'hC0, 3'd2, 3'b101);
    clr_in = 1'b1;
    wait_out("setwin_valid");
    chk("setwin_vf", vf_out, 1'b1);
    @(posedge clk); #1;
    clr_in = 1'b0;
    chk("sticky_set_wins", vf_sticky_out, 1'b1);
    clr_in = 1'b1;
    @(posedge clk); #1;
    clr_in = 1'b0;
    chk("sticky_clr_idle", vf_sticky_out, 1'b0);

    send(8'h01, 3'd1, 3'b000);
    wait_out("srl_valid");
    chk("srl_y", y_out, 8'h00);
    chk("srl_zf", zf_out, 1'b1);
    @(posedge clk); #1;

    for (int op = 0; op < 8; op++)
      send(8'hA5, 3'd0, op[2:0]);
    drain("drain_pass");
    chk("pass_last_y", y_out, 8'hA5);
    chk("pass_sticky", vf_sticky_out, 1'b0);
    @(posedge clk); #1;

    for (int xi = 0; xi < 4; xi++)
      for (int op = 0; op < 8; op++)
        if (op != 3 && op != 7)
          for (int s = 0; s < 8; s++)
            send(xs[xi], s[2:0], op[2:0]);
    drain("drain_sweep");
    @(posedge clk); #1;

    ready_out = 1'b0;
    base = delivered;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(8'h11 * (i + 1), 3'(i + 1), 3'b110);
      end
      begin
        int n;
        n = 0;
        while (ready_in && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_ready_drop", ready_in, 1'b0);
        chk("bp_valid_held", valid_out, 1'b1);
        chk("bp_head_y", y_out, 8'h22);
        repeat (4) @(negedge clk);
        chk("bp_head_still", y_out, 8'h22);
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    drain("drain_bp");
    chk("bp_count", delivered - base, 5);
    @(posedge clk); #1;

    send(8'h3C, 3'd2, 3'b000);
    send(8'hF0, 3'd1, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_y", y_out, 8'h00);
    chk("midrst_zf", zf_out, 1'b1);
    chk("midrst_vf", vf_out, 1'b0);
    chk("midrst_ready", ready_in, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = delivered;
    send(8'h0F, 3'd2, 3'b100);
    latency("post_rst_latency");
    chk("post_rst_y", y_out, 8'h3C);
    drain("drain_rst");
    repeat (6) @(negedge clk);
    chk("post_rst_count", delivered - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
